// File: rtl/seq_pkg.sv
// Shared types and defaults for the 0110 detector front end.
// The PARITY state is only reachable when SEQ_SERIALIZER_PARITY_EN is defined.
package seq_pkg;

    localparam int SEQ_WORD_WIDTH = 8;
    localparam bit SEQ_IDLE_BIT   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } seq_state_e;

endpackage

// File: rtl/seq_word_serializer.sv
// Word-to-bit serializer feeding the detector's x input, gapless across words.
// Optional trailing even-parity bit: define SEQ_SERIALIZER_PARITY_EN.
module seq_word_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH     = SEQ_WORD_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = SEQ_IDLE_BIT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             x_out,
    output logic             bit_valid,
    output logic             last_bit,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             x_q, x_d;
    logic             bv_q, bv_d;
    logic             lb_q, lb_d;
    logic             accept;
    logic             first_bit, next_bit;
    logic [WIDTH-1:0] load_rest, shift_rest;
`ifdef SEQ_SERIALIZER_PARITY_EN
    logic             par_q, par_d;
`endif

    // x_out holds the current bit; sreg holds the bits still to come.
    always_comb begin
        if (MSB_FIRST) begin
            first_bit  = load_data[WIDTH-1];
            load_rest  = load_data << 1;
            next_bit   = sreg_q[WIDTH-1];
            shift_rest = sreg_q << 1;
        end else begin
            first_bit  = load_data[0];
            load_rest  = load_data >> 1;
            next_bit   = sreg_q[0];
            shift_rest = sreg_q >> 1;
        end
    end

`ifdef SEQ_SERIALIZER_PARITY_EN
    assign load_ready = (state_q == IDLE) || (state_q == PARITY);
`else
    assign load_ready = (state_q == IDLE) ||
                        ((state_q == SHIFT) && (cnt_q == LAST));
`endif
    assign accept = load_valid && load_ready;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        x_d     = IDLE_BIT;
        bv_d    = 1'b0;
        lb_d    = 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
        par_d   = par_q;
`endif
        if (accept) begin
            state_d = SHIFT;
            sreg_d  = load_rest;
            cnt_d   = '0;
            x_d     = first_bit;
            bv_d    = 1'b1;
`ifdef SEQ_SERIALIZER_PARITY_EN
            par_d   = ^load_data;
`endif
        end else begin
            unique case (state_q)
                IDLE: state_d = IDLE;
                SHIFT: begin
                    if (cnt_q != LAST) begin
                        cnt_d  = cnt_q + 1'b1;
                        sreg_d = shift_rest;
                        x_d    = next_bit;
                        bv_d   = 1'b1;
`ifndef SEQ_SERIALIZER_PARITY_EN
                        lb_d   = (cnt_q == PENULT);
`endif
                    end else begin
`ifdef SEQ_SERIALIZER_PARITY_EN
                        state_d = PARITY;
                        x_d     = par_q;
                        bv_d    = 1'b1;
                        lb_d    = 1'b1;
`else
                        state_d = IDLE;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            x_q     <= IDLE_BIT;
            bv_q    <= 1'b0;
            lb_q    <= 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            bv_q    <= bv_d;
            lb_q    <= lb_d;
`ifdef SEQ_SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign x_out     = x_q;
    assign bit_valid = bv_q;
    assign last_bit  = lb_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_seq_word_serializer.sv
// Scoreboard bench for seq_word_serializer (MSB-first and LSB-first instances).
// Build with SEQ_SERIALIZER_PARITY_EN to exercise the parity bit.
module tb_seq_word_serializer;

`ifdef SEQ_SERIALIZER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clock, reset;
    logic [7:0] load_data, load_data2;
    logic       load_valid, load_valid2;
    logic       load_ready, x_out, bit_valid, last_bit, busy;
    logic       load_ready2, x_out2, bit_valid2, last_bit2, busy2;

    bit exp_q[$];
    bit last_q[$];
    int pass_cnt = 0;
    int total    = 0;

    seq_word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_dut (
        .clock(clock), .reset(reset),
        .load_data(load_data), .load_valid(load_valid),
        .load_ready(load_ready), .x_out(x_out),
        .bit_valid(bit_valid), .last_bit(last_bit), .busy(busy)
    );

    seq_word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
        .clock(clock), .reset(reset),
        .load_data(load_data2), .load_valid(load_valid2),
        .load_ready(load_ready2), .x_out(x_out2),
        .bit_valid(bit_valid2), .last_bit(last_bit2), .busy(busy2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic push_word(input logic [7:0] w, input bit msb);
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(msb ? w[7-k] : w[k]);
            last_q.push_back((NB == 8) && (k == 7));
        end
`ifdef SEQ_SERIALIZER_PARITY_EN
        exp_q.push_back(^w);
        last_q.push_back(1'b1);
`endif
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #1;
        total++; if (x_out !== 1'b1) $display("FAIL rst_x got %b exp 1", x_out); else pass_cnt++;
        total++; if (bit_valid !== 1'b0) $display("FAIL rst_bv got %b exp 0", bit_valid); else pass_cnt++;
        total++; if (last_bit !== 1'b0) $display("FAIL rst_lb got %b exp 0", last_bit); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else pass_cnt++;
        total++; if (load_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", load_ready); else pass_cnt++;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_single;
        bit eb, el;
        @(negedge clock);
        load_data = 8'h60; load_valid = 1'b1;
        total++; if (load_ready !== 1'b1) $display("FAIL single_ready got %b exp 1", load_ready); else pass_cnt++;
        push_word(8'h60, 1'b1);
        for (int i = 0; i < NB; i++) begin
            @(negedge clock);
            if (i == 0) load_valid = 1'b0;
            eb = exp_q.pop_front(); el = last_q.pop_front();
            total++; if (bit_valid !== 1'b1) $display("FAIL single_bv[%0d] got %b exp 1", i, bit_valid); else pass_cnt++;
            total++; if (x_out !== eb) $display("FAIL single_x[%0d] got %b exp %b", i, x_out, eb); else pass_cnt++;
            total++; if (last_bit !== el) $display("FAIL single_lb[%0d] got %b exp %b", i, last_bit, el); else pass_cnt++;
            total++; if (busy !== 1'b1) $display("FAIL single_busy[%0d] got %b exp 1", i, busy); else pass_cnt++;
        end
        @(negedge clock);
        total++; if (x_out !== 1'b1) $display("FAIL single_idle_x got %b exp 1", x_out); else pass_cnt++;
        total++; if (bit_valid !== 1'b0) $display("FAIL single_idle_bv got %b exp 0", bit_valid); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL single_idle_busy got %b exp 0", busy); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        bit eb, el, er;
        @(negedge clock);
        load_data = 8'h03; load_valid = 1'b1;
        push_word(8'h03, 1'b1);
        for (int i = 0; i < 2*NB; i++) begin
            @(negedge clock);
            if (i == 0) begin load_data = 8'h60; push_word(8'h60, 1'b1); end
            if (i == NB) begin load_valid = 1'b0; load_data = 8'hFF; end
            er = (i == NB-1) || (i == 2*NB-1);
            eb = exp_q.pop_front(); el = last_q.pop_front();
            total++; if (bit_valid !== 1'b1) $display("FAIL b2b_bv[%0d] got %b exp 1", i, bit_valid); else pass_cnt++;
            total++; if (x_out !== eb) $display("FAIL b2b_x[%0d] got %b exp %b", i, x_out, eb); else pass_cnt++;
            total++; if (last_bit !== el) $display("FAIL b2b_lb[%0d] got %b exp %b", i, last_bit, el); else pass_cnt++;
            total++; if (load_ready !== er) $display("FAIL b2b_ready[%0d] got %b exp %b", i, load_ready, er); else pass_cnt++;
        end
        @(negedge clock);
        total++; if (bit_valid !== 1'b0) $display("FAIL b2b_idle_bv got %b exp 0", bit_valid); else pass_cnt++;
        total++; if (exp_q.size() != 0) $display("FAIL b2b_sb_left got %0d exp 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_wait_busy;
        bit eb, el, er;
        @(negedge clock);
        load_data = 8'hC5; load_valid = 1'b1;
        push_word(8'hC5, 1'b1);
        for (int i = 0; i < 2*NB; i++) begin
            @(negedge clock);
            if (i == 0) load_valid = 1'b0;
            if (i == 1) begin load_valid = 1'b1; load_data = 8'h3A; push_word(8'h3A, 1'b1); end
            if (i == NB) begin load_valid = 1'b0; load_data = 8'h00; end
            er = (i == NB-1) || (i == 2*NB-1);
            eb = exp_q.pop_front(); el = last_q.pop_front();
            total++; if (bit_valid !== 1'b1) $display("FAIL wait_bv[%0d] got %b exp 1", i, bit_valid); else pass_cnt++;
            total++; if (x_out !== eb) $display("FAIL wait_x[%0d] got %b exp %b", i, x_out, eb); else pass_cnt++;
            total++; if (last_bit !== el) $display("FAIL wait_lb[%0d] got %b exp %b", i, last_bit, el); else pass_cnt++;
            total++; if (load_ready !== er) $display("FAIL wait_ready[%0d] got %b exp %b", i, load_ready, er); else pass_cnt++;
        end
        @(negedge clock);
        total++; if (x_out !== 1'b1) $display("FAIL wait_idle_x got %b exp 1", x_out); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        bit eb, el;
        @(negedge clock);
        load_data = 8'hFF; load_valid = 1'b1;
        push_word(8'hFF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (i == 0) load_valid = 1'b0;
            eb = exp_q.pop_front(); el = last_q.pop_front();
            total++; if (x_out !== eb) $display("FAIL rmid_x[%0d] got %b exp %b", i, x_out, eb); else pass_cnt++;
        end
        #2 reset = 1'b1;
        #1;
        total++; if (x_out !== 1'b1) $display("FAIL rmid_async_x got %b exp 1", x_out); else pass_cnt++;
        total++; if (bit_valid !== 1'b0) $display("FAIL rmid_async_bv got %b exp 0", bit_valid); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL rmid_async_busy got %b exp 0", busy); else pass_cnt++;
        total++; if (load_ready !== 1'b1) $display("FAIL rmid_async_ready got %b exp 1", load_ready); else pass_cnt++;
        exp_q.delete(); last_q.delete();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        total++; if (bit_valid !== 1'b0) $display("FAIL rmid_noresume_bv got %b exp 0", bit_valid); else pass_cnt++;
        load_data = 8'h00; load_valid = 1'b1;
        push_word(8'h00, 1'b1);
        for (int i = 0; i < NB; i++) begin
            @(negedge clock);
            if (i == 0) load_valid = 1'b0;
            eb = exp_q.pop_front(); el = last_q.pop_front();
            total++; if (bit_valid !== 1'b1) $display("FAIL rmid_zero_bv[%0d] got %b exp 1", i, bit_valid); else pass_cnt++;
            total++; if (x_out !== eb) $display("FAIL rmid_zero_x[%0d] got %b exp %b", i, x_out, eb); else pass_cnt++;
        end
        @(negedge clock);
        total++; if (bit_valid !== 1'b0) $display("FAIL rmid_idle_bv got %b exp 0", bit_valid); else pass_cnt++;
    endtask

    task automatic test_lsb_first;
        bit eb, el;
        @(negedge clock);
        load_data2 = 8'b0000_0110; load_valid2 = 1'b1;
        total++; if (load_ready2 !== 1'b1) $display("FAIL lsb_ready got %b exp 1", load_ready2); else pass_cnt++;
        push_word(8'b0000_0110, 1'b0);
        for (int i = 0; i < NB; i++) begin
            @(negedge clock);
            if (i == 0) load_valid2 = 1'b0;
            eb = exp_q.pop_front(); el = last_q.pop_front();
            total++; if (bit_valid2 !== 1'b1) $display("FAIL lsb_bv[%0d] got %b exp 1", i, bit_valid2); else pass_cnt++;
            total++; if (x_out2 !== eb) $display("FAIL lsb_x[%0d] got %b exp %b", i, x_out2, eb); else pass_cnt++;
            total++; if (last_bit2 !== el) $display("FAIL lsb_lb[%0d] got %b exp %b", i, last_bit2, el); else pass_cnt++;
        end
        @(negedge clock);
        total++; if (x_out2 !== 1'b1) $display("FAIL lsb_idle_x got %b exp 1", x_out2); else pass_cnt++;
        total++; if (busy2 !== 1'b0) $display("FAIL lsb_idle_busy got %b exp 0", busy2); else pass_cnt++;
    endtask

`ifdef SEQ_SERIALIZER_PARITY_EN
    task automatic test_parity;
        bit eb, el, er;
        @(negedge clock);
        load_data = 8'hA5; load_valid = 1'b1;
        push_word(8'hA5, 1'b1);
        for (int i = 0; i < 2*NB; i++) begin
            @(negedge clock);
            if (i == 0) begin load_data = 8'h07; push_word(8'h07, 1'b1); end
            if (i == NB) load_valid = 1'b0;
            er = (i == NB-1) || (i == 2*NB-1);
            eb = exp_q.pop_front(); el = last_q.pop_front();
            total++; if (x_out !== eb) $display("FAIL par_x[%0d] got %b exp %b", i, x_out, eb); else pass_cnt++;
            total++; if (last_bit !== el) $display("FAIL par_lb[%0d] got %b exp %b", i, last_bit, el); else pass_cnt++;
            total++; if (load_ready !== er) $display("FAIL par_ready[%0d] got %b exp %b", i, load_ready, er); else pass_cnt++;
            total++; if (bit_valid !== 1'b1) $display("FAIL par_bv[%0d] got %b exp 1", i, bit_valid); else pass_cnt++;
            if (i == NB-1) begin
                total++; if (x_out !== 1'b0) $display("FAIL par_a5 got %b exp 0", x_out); else pass_cnt++;
            end
            if (i == 2*NB-1) begin
                total++; if (x_out !== 1'b1) $display("FAIL par_07 got %b exp 1", x_out); else pass_cnt++;
            end
        end
        @(negedge clock);
        total++; if (bit_valid !== 1'b0) $display("FAIL par_idle_bv got %b exp 0", bit_valid); else pass_cnt++;
    endtask
`endif

    initial begin
        load_data = '0; load_valid = 1'b0;
        load_data2 = '0; load_valid2 = 1'b0;
        reset = 1'b1;
        test_reset;
        test_single;
        test_back_to_back;
        test_wait_busy;
        test_reset_mid;
        test_lsb_first;
`ifdef SEQ_SERIALIZER_PARITY_EN
        test_parity;
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1);
    end

endmodule
